// File: rtl/phase2_ctrl.sv
// phase2_ctrl: column-sweep sequencer for the phase-2 teta update datapath.
// Define PHASE2_CTRL_CONV_EN to end a run early once a full sweep leaves every teta unchanged.
module phase2_ctrl #(
  parameter  int N      = 8,
  parameter  int DW     = 8,
  parameter  int ITER_W = 8,
  parameter  int LAT    = 2,
  localparam int AW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] num_iter,
  input  logic [DW-1:0]     epsilon_in,
  input  logic              teta_ld_en,
  input  logic [AW-1:0]     teta_ld_addr,
  input  logic [DW-1:0]     teta_ld_data,
  input  logic [AW-1:0]     teta_rd_addr,
  output logic [DW-1:0]     teta_rd_data,
  output logic [AW-1:0]     col_addr,
  output logic              col_rd_en,
  output logic              dp_enable,
  output logic [DW-1:0]     dp_epsilon,
  output logic [DW-1:0]     dp_teta_i_t,
  input  logic [DW-1:0]     dp_teta,
  output logic              busy,
  output logic              done,
  output logic              converged
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              LW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LW-1:0]   LAT_LAST = LW'(LAT - 1);
  localparam logic [AW-1:0]   COL_LAST = AW'(N - 1);

  logic [2:0]        state;
  logic [AW-1:0]     col;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] num_iter_q;
  logic [DW-1:0]     eps_q;
  logic [LW-1:0]     lat_cnt;
  logic [DW-1:0]     teta_reg [N];

  logic              start_ok;
  logic              last_col;
  logic [ITER_W-1:0] iter_inc;
  logic              last_sweep;
  logic              stop_early;

  assign start_ok   = (state == S_IDLE) && start;
  assign last_col   = (col == COL_LAST);
  assign iter_inc   = iter + ITER_W'(1);
  assign last_sweep = last_col && (iter_inc == num_iter_q);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      col        <= '0;
      iter       <= '0;
      num_iter_q <= '0;
      eps_q      <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            col        <= '0;
            iter       <= '0;
            num_iter_q <= num_iter;
            eps_q      <= epsilon_in;
            state      <= (num_iter == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          lat_cnt <= '0;
          state   <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (abort)                    state   <= S_IDLE;
          else if (lat_cnt == LAT_LAST) state   <= S_WB;
          else                          lat_cnt <= lat_cnt + LW'(1);
        end
        S_WB: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (last_col) begin
            col   <= '0;
            iter  <= iter_inc;
            state <= (last_sweep || stop_early) ? S_DONE : S_FETCH;
          end else begin
            col   <= col + AW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the teta bank must read back as zero after reset, so it is a
  // reset register file rather than an uninitialised RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) teta_reg[i] <= '0;
    end else if (state == S_WB) begin
      teta_reg[col] <= dp_teta;
    end else if ((state == S_IDLE) && teta_ld_en) begin
      teta_reg[teta_ld_addr] <= teta_ld_data;
    end
  end

`ifdef PHASE2_CTRL_CONV_EN
  logic changed;
  logic conv_q;
  logic wb_diff;

  assign wb_diff    = (dp_teta != teta_reg[col]);
  // The last WB of a sweep counts its own change when deciding convergence.
  assign stop_early = last_col && !(changed || wb_diff);
  assign converged  = conv_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      changed <= 1'b0;
      conv_q  <= 1'b0;
    end else if (start_ok) begin
      changed <= 1'b0;
      conv_q  <= 1'b0;
    end else if ((state == S_WB) && !abort) begin
      changed <= last_col ? 1'b0 : (changed | wb_diff);
      if (stop_early) conv_q <= 1'b1;
    end
  end
`else
  assign stop_early = 1'b0;
  assign converged  = 1'b0;
`endif

  assign busy         = (state == S_FETCH) || (state == S_RUN) || (state == S_WB);
  assign done         = (state == S_DONE);
  assign col_rd_en    = (state == S_FETCH);
  assign dp_enable    = (state == S_RUN);
  assign col_addr     = col;
  assign dp_teta_i_t  = teta_reg[col];
  assign dp_epsilon   = eps_q;
  assign teta_rd_data = teta_reg[teta_rd_addr];

endmodule

// File: tb/tb_phase2_ctrl.sv
// Directed testbench for phase2_ctrl (N=8, DW=8, ITER_W=8, LAT=2).
// The datapath is modelled as teta+epsilon, or as a pure echo for the convergence run.
module tb_phase2_ctrl;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       abort;
  logic [7:0] num_iter;
  logic [7:0] epsilon_in;
  logic       teta_ld_en;
  logic [2:0] teta_ld_addr;
  logic [7:0] teta_ld_data;
  logic [2:0] teta_rd_addr;
  logic [7:0] teta_rd_data;
  logic [2:0] col_addr;
  logic       col_rd_en;
  logic       dp_enable;
  logic [7:0] dp_epsilon;
  logic [7:0] dp_teta_i_t;
  logic [7:0] dp_teta;
  logic       busy;
  logic       done;
  logic       converged;
  logic       echo;

  phase2_ctrl #(.N(8), .DW(8), .ITER_W(8), .LAT(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .num_iter     (num_iter),
    .epsilon_in   (epsilon_in),
    .teta_ld_en   (teta_ld_en),
    .teta_ld_addr (teta_ld_addr),
    .teta_ld_data (teta_ld_data),
    .teta_rd_addr (teta_rd_addr),
    .teta_rd_data (teta_rd_data),
    .col_addr     (col_addr),
    .col_rd_en    (col_rd_en),
    .dp_enable    (dp_enable),
    .dp_epsilon   (dp_epsilon),
    .dp_teta_i_t  (dp_teta_i_t),
    .dp_teta      (dp_teta),
    .busy         (busy),
    .done         (done),
    .converged    (converged)
  );

  assign dp_teta = echo ? dp_teta_i_t : (dp_teta_i_t + dp_epsilon);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   cyc;
  int   done_cyc;
  int   pulse_addr[$];
  int   pulse_cyc[$];
  logic snap_rd1, snap_busy1, snap_en2, snap_busy_post, snap_busy_last, conv_at_done;
  logic [7:0] snap_ti2, snap_eps2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_teta(input logic [2:0] addr, input logic [7:0] exp, input string tag);
    teta_rd_addr = addr;
    #1;
    check(tag, teta_rd_data, exp);
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      teta_ld_en   = 1'b1;
      teta_ld_addr = 3'(i);
      teta_ld_data = 8'(16 * i + 1);
      @(negedge clk);
    end
    teta_ld_en = 1'b0;
  endtask

  // Cycle 0 is the edge that samples start; the state seen at negedge k is cycle k.
  task automatic run_op(input logic [7:0] n_it, input logic [7:0] eps,
                        input int restart_cyc, input int abort_cyc,
                        input int ld_cyc, input logic [2:0] ld_addr,
                        input logic [7:0] ld_data, input int budget);
    cyc      = 0;
    done_cyc = -1;
    pulse_addr.delete();
    pulse_cyc.delete();
    num_iter   = n_it;
    epsilon_in = eps;
    while (1) begin
      start        = (cyc == 0) || (cyc == restart_cyc);
      abort        = (cyc == abort_cyc);
      teta_ld_en   = (cyc == ld_cyc);
      teta_ld_addr = ld_addr;
      teta_ld_data = ld_data;
      @(negedge clk);
      cyc++;
      if (col_rd_en) begin
        pulse_addr.push_back(int'(col_addr));
        pulse_cyc.push_back(cyc);
      end
      if (cyc == 1) begin
        snap_rd1   = col_rd_en;
        snap_busy1 = busy;
      end
      if (cyc == 2) begin
        snap_en2  = dp_enable;
        snap_ti2  = dp_teta_i_t;
        snap_eps2 = dp_epsilon;
      end
      if (cyc == abort_cyc + 1) snap_busy_post = busy;
      snap_busy_last = busy;
      if (done && done_cyc < 0) begin
        done_cyc     = cyc;
        conv_at_done = converged;
      end
      if (done_cyc >= 0 || cyc >= budget) break;
    end
    start      = 1'b0;
    abort      = 1'b0;
    teta_ld_en = 1'b0;
  endtask

  initial begin
    logic ok;
    int   wraps;

    resetn = 1'b0; start = 1'b0; abort = 1'b0; num_iter = '0; epsilon_in = '0;
    teta_ld_en = 1'b0; teta_ld_addr = '0; teta_ld_data = '0; teta_rd_addr = 3'd3; echo = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_col_rd_en", col_rd_en, 1'b0);
    check("rst_dp_enable", dp_enable, 1'b0);
    check("rst_converged", converged, 1'b0);
    check("rst_teta3", teta_rd_data, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // A: one sweep, teta += 5; a load attempt while busy must be dropped.
    preload();
    run_op(8'd1, 8'd5, -1, -1, 6, 3'd0, 8'hFF, 200);
    check("A_done_cycle", done_cyc, 33);
    check("A_fetch_rd_en", snap_rd1, 1'b1);
    check("A_fetch_busy", snap_busy1, 1'b1);
    check("A_run_dp_enable", snap_en2, 1'b1);
    check("A_run_teta_i_t", snap_ti2, 8'h01);
    check("A_run_epsilon", snap_eps2, 8'h05);
    check("A_pulse_count", pulse_addr.size(), 8);
    ok = 1'b1;
    for (int i = 0; i < pulse_addr.size(); i++)
      if (pulse_addr[i] != i || pulse_cyc[i] != 1 + 4 * i) ok = 1'b0;
    check("A_pulse_seq", ok, 1'b1);
    @(negedge clk);
    check("A_done_pulse_width", done, 1'b0);
    check("A_idle_busy", busy, 1'b0);
    read_teta(3'd0, 8'h06, "A_teta0");
    read_teta(3'd3, 8'h36, "A_teta3");
    read_teta(3'd7, 8'h76, "A_teta7");

    // B: num_iter == 0 goes straight to DONE.
    @(negedge clk);
    run_op(8'd0, 8'd5, -1, -1, -1, 3'd0, 8'h00, 20);
    check("B_done_cycle", done_cyc, 1);
    check("B_pulse_count", pulse_addr.size(), 0);
    read_teta(3'd0, 8'h06, "B_teta0");
    read_teta(3'd5, 8'h56, "B_teta5");

    // C: three sweeps, load coincident with start, stray start at cycle 10.
    @(negedge clk);
    run_op(8'd3, 8'd1, 10, -1, 0, 3'd0, 8'h80, 400);
    check("C_done_cycle", done_cyc, 97);
    check("C_pulse_count", pulse_addr.size(), 24);
    wraps = 0;
    for (int i = 1; i < pulse_addr.size(); i++)
      if (pulse_addr[i - 1] == 7 && pulse_addr[i] == 0) wraps++;
    check("C_wraps", wraps, 2);
    read_teta(3'd0, 8'h83, "C_teta0_loaded");
    read_teta(3'd1, 8'h19, "C_teta1");
    read_teta(3'd7, 8'h79, "C_teta7");

    // D: abort in the first RUN cycle of column 3.
    @(negedge clk);
    preload();
    run_op(8'd1, 8'd2, -1, 14, -1, 3'd0, 8'h00, 40);
    check("D_no_done", done_cyc, -1);
    check("D_busy_after_abort", snap_busy_post, 1'b0);
    check("D_busy_end", snap_busy_last, 1'b0);
    check("D_pulse_count", pulse_addr.size(), 4);
    read_teta(3'd0, 8'h03, "D_teta0");
    read_teta(3'd2, 8'h23, "D_teta2");
    read_teta(3'd3, 8'h31, "D_teta3");
    read_teta(3'd7, 8'h71, "D_teta7");

    // E: reset during cycle 20 of a run, then a clean run.
    @(negedge clk);
    run_op(8'd1, 8'd5, -1, -1, -1, 3'd0, 8'h00, 20);
    check("E_busy_before_reset", snap_busy_last, 1'b1);
    teta_rd_addr = 3'd1;
    resetn = 1'b0;
    #1;
    check("E_rst_busy", busy, 1'b0);
    check("E_rst_done", done, 1'b0);
    check("E_rst_rd_en", col_rd_en, 1'b0);
    check("E_rst_dp_enable", dp_enable, 1'b0);
    check("E_rst_teta1", teta_rd_data, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(8'd1, 8'd5, -1, -1, -1, 3'd0, 8'h00, 200);
    check("E_done_cycle", done_cyc, 33);
    read_teta(3'd1, 8'h05, "E_teta1");

    // F: echoing datapath, five sweeps requested.
    @(negedge clk);
    echo = 1'b1;
    run_op(8'd5, 8'd9, -1, -1, -1, 3'd0, 8'h00, 400);
`ifdef PHASE2_CTRL_CONV_EN
    check("F_done_cycle", done_cyc, 33);
    check("F_converged_at_done", conv_at_done, 1'b1);
    @(negedge clk);
    check("F_converged_held", converged, 1'b1);
`else
    check("F_done_cycle", done_cyc, 161);
    check("F_converged_at_done", conv_at_done, 1'b0);
    @(negedge clk);
    check("F_converged_held", converged, 1'b0);
`endif
    read_teta(3'd4, 8'h05, "F_teta4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase2_ctrl.md
PHASE2_CTRL -- requirements
Module: phase2_ctrl

Interface
REQ-001 Parameter N, default 8: number of teta coefficients (columns) per sweep; power of two.
REQ-002 Parameter DW, default 8: teta/epsilon width in bits.
REQ-003 Parameter ITER_W, default 8: width of the iteration count.
REQ-004 Parameter LAT, default 2: datapath compute cycles per column; LAT >= 1.
REQ-005 clk  in  1  rising-edge clock; the single clock of the block.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  pulse; begins a run when sampled in IDLE.
REQ-008 abort  in  1  synchronous abort of a run in progress.
REQ-009 num_iter  in  ITER_W  number of full sweeps; sampled with start.
REQ-010 epsilon_in  in  DW  step size; sampled with start.
REQ-011 teta_ld_en / teta_ld_addr / teta_ld_data  in  1 / log2N / DW  preload port for teta registers.
REQ-012 teta_rd_addr  in  log2N; teta_rd_data  out  DW  combinational readback of teta registers.
REQ-013 col_addr  out  log2N  column index driving the x_col/h/y source memory.
REQ-014 col_rd_en  out  1  one-cycle read strobe to the column memory.
REQ-015 dp_enable  out  1  datapath enable; dp_epsilon  out  DW; dp_teta_i_t  out  DW  current teta.
REQ-016 dp_teta  in  DW  updated teta from the datapath.
REQ-017 busy  out  1; done  out  1; converged  out  1.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, RUN, WB and DONE.
- IDLE->FETCH on start; col=0, iter=0.
- FETCH->RUN after 1 cycle.
- RUN->WB after exactly LAT cycles.
- WB->FETCH for the next column, or WB->DONE after the last column of the last sweep.
- DONE->IDLE after 1 cycle.
REQ-019 In IDLE, if num_iter==0 when start is sampled, the FSM SHALL go directly to DONE; teta registers SHALL be unchanged.
REQ-020 col_rd_en SHALL be 1 only in FETCH; col_addr SHALL hold the current column from FETCH through WB.
REQ-021 dp_enable SHALL be 1 only in RUN; dp_teta_i_t SHALL equal teta_reg[col] and dp_epsilon the latched epsilon.
REQ-022 In WB, teta_reg[col] SHALL capture dp_teta.
- If col==N-1, col SHALL wrap to 0 and iter SHALL increment.
- The run ends when the incremented iter equals num_iter.
REQ-023 busy SHALL be 1 in FETCH, RUN and WB; done SHALL be a 1-cycle pulse in DONE.
REQ-024 With start sampled at cycle 0 and no abort, done SHALL assert at cycle num_iter*N*(LAT+2)+1.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 teta_ld_en SHALL write teta_reg[teta_ld_addr] only in IDLE; it SHALL be ignored otherwise.
REQ-027 If start and teta_ld_en are high in the same IDLE cycle, the load SHALL complete and the first FETCH SHALL see the loaded value.
REQ-028 abort in FETCH/RUN/WB SHALL return the FSM to IDLE next cycle.
- No done pulse.
- A WB coinciding with abort SHALL still write.
- Other teta registers SHALL keep partial results.
REQ-029 abort in IDLE or DONE SHALL have no effect; the DONE pulse SHALL still complete.

Reset
REQ-030 On resetn low, asynchronously:
- state=IDLE; col=0; iter=0.
- All teta registers, latched epsilon and latched num_iter = 0.
- busy, done, col_rd_en, dp_enable, converged = 0.
REQ-031 Reset mid-run SHALL discard the run with no done pulse; operation SHALL resume on the first clk edge after resetn rises.

Configuration
REQ-032 Macro PHASE2_CTRL_CONV_EN defined:
- The block SHALL track whether any WB in the current sweep changed its teta value.
- A sweep with no change SHALL end the run early at that sweep's last WB: DONE, converged=1.
- converged SHALL hold until the next accepted start or reset.
REQ-033 Macro PHASE2_CTRL_CONV_EN undefined: converged SHALL be tied 0 and all num_iter sweeps SHALL always run.

Verification
REQ-034 Scenario A (N=8, LAT=2): preload teta, num_iter=1, start at cycle 0 -> 8 col_rd_en pulses at col_addr 0..7, one every 4 cycles; done at cycle 33; teta_rd_data shows dp_teta values.
REQ-035 Scenario B: num_iter=0 -> done at cycle 1; no col_rd_en; teta unchanged.
REQ-036 Scenario C: num_iter=3 -> col_addr wraps 7->0 twice; done at cycle 97; start pulsed at cycle 10 ignored.
REQ-037 Scenario D: abort during RUN of column 3 -> IDLE next cycle; busy 0; no done; teta[0..2] updated, teta[3..7] preloaded values.
REQ-038 Scenario E: resetn low at cycle 20 of a run -> all outputs 0 immediately; a new start after release completes normally.
REQ-039 Scenario F (CONV_EN): datapath echoes dp_teta_i_t, num_iter=5 -> done at cycle 33 with converged=1; without the macro, done at cycle 161 with converged=0.
